// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared processor constants: memory opcodes and controller states
package mem_access_ctrl_pkg;

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    function automatic logic is_mem_op(input logic [4:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - clearable up-counter flagging its TERMINAL-th counted cycle
module cycle_counter #(
    parameter int TERMINAL = 16,
    parameter int W        = $clog2(TERMINAL + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    // count is 0 in the first enabled cycle, so LAST marks the TERMINAL-th one
    assign tc = enable && (count == LAST);

endmodule

// File: rtl/dflipflop.sv
// rtl/dflipflop.sv - single-bit D flip-flop with asynchronous active-high reset
module dflipflop (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end

endmodule

// File: rtl/register.sv
// rtl/register.sv - enabled multi-bit register with asynchronous active-high reset
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - M-stage data-memory access controller with stall and timeout
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ir_in,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic [31:0]       wb_data,
    output logic              mem_error
);

    state_t            state;
    logic [4:0]        opcode;
    logic              mem_op;
    logic              ir_is_lw;
    logic              in_access;
    logic              timeout_tc;
    logic              lw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              ack_hit;
    logic              timeout_hit;
    logic              rdata_en;
    logic [31:0]       rdata_d;
    logic [31:0]       rdata_q;
    logic              unused_ir;

    assign opcode    = ir_in[31:27];
    assign mem_op    = is_mem_op(opcode);
    assign ir_is_lw  = (opcode == OP_LW);
    assign in_access = (state == ST_ACCESS);
    assign unused_ir = ^ir_in[26:0];

    cycle_counter #(
        .TERMINAL(TIMEOUT)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (!in_access),
        .enable(in_access),
        .tc    (timeout_tc)
    );

    // ack has priority over the terminal count on the same edge
    assign ack_hit     = in_access && dmem_ack;
    assign timeout_hit = in_access && !dmem_ack && timeout_tc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            lw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        state    <= ST_ACCESS;
                        dmem_req <= 1'b1;
                        dmem_we  <= (opcode == OP_SW);
                        lw_q     <= ir_is_lw;
                        addr_q   <= o_in[ADDR_W-1:0];
                        wdata_q  <= b_in;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state    <= ST_DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else if (timeout_tc) begin
                        state    <= ST_ERR;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: begin
                    state    <= ST_IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

    // a timeout flushes the load result to zero
    assign rdata_en = (ack_hit && lw_q) || timeout_hit;
    assign rdata_d  = timeout_hit ? 32'h0 : dmem_rdata;

    register #(
        .WIDTH(32)
    ) u_rdata (
        .clock(clock),
        .reset(reset),
        .en   (rdata_en),
        .d    (rdata_d),
        .q    (rdata_q)
    );

    dflipflop u_mem_error (
        .clock(clock),
        .reset(reset),
        .d    (mem_error || timeout_hit),
        .q    (mem_error)
    );

    // address and data come from the captured copy while the access is in flight
    assign dmem_addr  = in_access ? addr_q  : o_in[ADDR_W-1:0];
    assign dmem_wdata = in_access ? wdata_q : b_in;

    assign stall_out = ((state == ST_IDLE) && mem_op) || in_access;
    assign wb_data   = ir_is_lw ? rdata_q : o_in;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int ADDR_W = 12;
    localparam logic [31:0] IR_LW = 32'h4000_0000;
    localparam logic [31:0] IR_SW = 32'h3800_0000;

    logic              clock;
    logic              reset;
    logic [31:0]       ir_in;
    logic [31:0]       o_in;
    logic [31:0]       b_in;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic              stall_out;
    logic [31:0]       wb_data;
    logic              mem_error;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(
        .TIMEOUT(16),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ir_in     (ir_in),
        .o_in      (o_in),
        .b_in      (b_in),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .stall_out (stall_out),
        .wb_data   (wb_data),
        .mem_error (mem_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] o;
        logic [31:0] b;
        logic        exp_stall;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int stalls;
        int req_cycles;

        vecs[0] = '{32'h0000_0000, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_0011};
        vecs[1] = '{32'h0800_0003, 32'h0000_0007, 32'h0,         1'b0, 32'h0000_0007};
        vecs[2] = '{32'h4800_0000, 32'h0000_0ABC, 32'h0,         1'b0, 32'h0000_0ABC};
        vecs[3] = '{32'h3000_0000, 32'h0000_0055, 32'h0,         1'b0, 32'h0000_0055};
        vecs[4] = '{32'h4000_1234, 32'h0000_0999, 32'h0,         1'b1, 32'h0000_0000};
        vecs[5] = '{32'h3800_00FF, 32'h0000_0077, 32'h0000_0001, 1'b1, 32'h0000_0077};
        vecs[6] = '{32'hF800_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'hFFFF_FFFF};

        reset      = 1'b1;
        ir_in      = '0;
        o_in       = 32'h0000_0033;
        b_in       = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_req", 32'(dmem_req), 32'd0);
        check("reset_we", 32'(dmem_we), 32'd0);
        check("reset_stall", 32'(stall_out), 32'd0);
        check("reset_err", 32'(mem_error), 32'd0);
        check("reset_wb", wb_data, 32'h0000_0033);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            tick();
            ir_in = vecs[i].ir;
            o_in  = vecs[i].o;
            b_in  = vecs[i].b;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall_out), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_req", i), 32'(dmem_req), 32'd0);
            check($sformatf("vec%0d_wb", i), wb_data, vecs[i].exp_wb);
            ir_in = '0;
        end

        // lw, ack on 2nd ACCESS cycle
        tick();
        ir_in = IR_LW; o_in = 32'h0000_0040; b_in = 32'h0;
        stalls = 0;
        #1;
        stalls += int'(stall_out);
        check("lw_idle_req", 32'(dmem_req), 32'd0);
        tick();
        stalls += int'(stall_out);
        check("lw_a1_req", 32'(dmem_req), 32'd1);
        check("lw_a1_we", 32'(dmem_we), 32'd0);
        check("lw_a1_addr", 32'(dmem_addr), 32'h040);
        tick();
        stalls += int'(stall_out);
        check("lw_a2_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        stalls += int'(stall_out);
        check("lw_done_req", 32'(dmem_req), 32'd0);
        check("lw_done_wb", wb_data, 32'hDEAD_BEEF);
        check("lw_stall_cycles", 32'(stalls), 32'd3);
        ir_in = '0;
        tick();
        check("lw_idle_after", 32'(stall_out), 32'd0);

        // sw, ack on 1st ACCESS cycle
        ir_in = IR_SW; o_in = 32'h0000_0010; b_in = 32'h0000_1234;
        stalls = 0;
        #1;
        stalls += int'(stall_out);
        tick();
        stalls += int'(stall_out);
        check("sw_a1_req", 32'(dmem_req), 32'd1);
        check("sw_a1_we", 32'(dmem_we), 32'd1);
        check("sw_a1_wdata", dmem_wdata, 32'h0000_1234);
        check("sw_a1_addr", 32'(dmem_addr), 32'h010);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        stalls += int'(stall_out);
        check("sw_done_req", 32'(dmem_req), 32'd0);
        check("sw_done_wb", wb_data, 32'h0000_0010);
        check("sw_stall_cycles", 32'(stalls), 32'd2);
        ir_in = '0;
        tick();

        // ack on the TIMEOUT-th ACCESS cycle wins
        ir_in = IR_LW; o_in = 32'h0000_0020; b_in = 32'h0;
        tick();
        for (int k = 0; k < 15; k++) tick();
        check("edge_a16_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        check("edge_done_req", 32'(dmem_req), 32'd0);
        check("edge_done_err", 32'(mem_error), 32'd0);
        check("edge_done_wb", wb_data, 32'hCAFE_F00D);
        check("edge_done_stall", 32'(stall_out), 32'd0);
        ir_in = '0;
        tick();

        // lw with no ack times out
        ir_in = IR_LW; o_in = 32'h0000_0080;
        tick();
        req_cycles = 0;
        for (int k = 0; k < 40 && dmem_req; k++) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_err_flag", 32'(mem_error), 32'd1);
        check("to_err_wb", wb_data, 32'h0);
        check("to_err_stall", 32'(stall_out), 32'd0);
        ir_in = '0;
        tick();
        tick();
        check("to_err_sticky", 32'(mem_error), 32'd1);

        // reset on 3rd ACCESS cycle, then a late ack
        ir_in = IR_LW; o_in = 32'h0000_0100;
        tick();
        tick();
        tick();
        check("rst_a3_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_req", 32'(dmem_req), 32'd0);
        check("rst_async_we", 32'(dmem_we), 32'd0);
        check("rst_async_err", 32'(mem_error), 32'd0);
        check("rst_async_wb", wb_data, 32'h0);
        ir_in = '0;
        #1;
        check("rst_idle_stall", 32'(stall_out), 32'd0);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_stall", 32'(stall_out), 32'd0);
        check("late_ack_err", 32'(mem_error), 32'd0);
        ir_in = IR_LW;
        #1;
        check("late_ack_wb", wb_data, 32'h0);
        check("late_ack_lw_stall", 32'(stall_out), 32'd1);
        ir_in = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
